// File: rtl/cam_clk_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cam_clk_seq
//  Brief    : Camera master-clock divider plus power-down / reset sequencer.
//             Brings the sensor up in the order power -> clock -> reset
//             release, tears it down in the reverse order, and applies
//             divider reprogramming only on a low->high XCLK toggle so no
//             runt phases are ever produced.
//  Revision : 1.0  initial release
// ============================================================================
module cam_clk_seq #(
  parameter int DIV_W         = 8,
  parameter int DIV_INIT      = 4,
  parameter int PWR_CYCLES    = 256,
  parameter int SETTLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div_half,
  input  logic             div_load,
  output logic             div_ack,
  output logic             cam_clk,
  output logic             cam_pwdn,
  output logic             cam_rst_n,
  output logic             ready,
  output logic             busy
);

  // Shared wait counter is sized for the longest of the three waits.
  localparam int MAX_PS  = (PWR_CYCLES > SETTLE_CYCLES) ? PWR_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_PS > HOLD_CYCLES) ? MAX_PS : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PWR_LAST    = CNT_W'(PWR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_VAL    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};
  localparam logic [DIV_W-1:0] DIV_RST     = DIV_W'(DIV_INIT);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_PWRUP = 3'd1,
    S_CLKON = 3'd2,
    S_RUN   = 3'd3,
    S_PWRDN = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   hcnt_q, hcnt_d;
  logic               cam_clk_q, cam_clk_d;
  logic [DIV_W-1:0]   div_cur_q, div_cur_d;
  logic [DIV_W-1:0]   pend_val_q, pend_val_d;
  logic               pending_q, pending_d;
  logic               div_ack_q, div_ack_d;
  logic               cam_pwdn_q, cam_pwdn_d;
  logic               cam_rst_n_q, cam_rst_n_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic               hold_done;
  logic               freeze;
  logic               div_run;
  logic               div_stopped;
  logic               half_done;
  logic               tick;
  logic               apply;

  // Divider run/freeze qualifiers shared by the FSM and the divider logic.
  always_comb begin
    hold_done   = (cnt_q >= HOLD_VAL);
    // Teardown stops the clock only while it is low, so a high phase is
    // never cut short.
    freeze      = (state_q == S_PWRDN) && hold_done && !cam_clk_q;
    div_run     = (state_q == S_CLKON) || (state_q == S_RUN) || (state_q == S_PWRDN);
    div_stopped = (state_q == S_OFF) || (state_q == S_PWRUP);
    half_done   = (hcnt_q >= div_cur_q);
    tick        = div_run && !freeze && half_done;
  end

  // Sequencer next-state, wait counter and registered output decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF: begin
        if (start && !stop) state_d = S_PWRUP;
      end
      S_PWRUP: begin
        if (stop)                     state_d = S_OFF;
        else if (cnt_q == PWR_LAST)   state_d = S_CLKON;
      end
      S_CLKON: begin
        if (stop)                      state_d = S_PWRDN;
        else if (cnt_q == SETTLE_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop) state_d = S_PWRDN;
      end
      S_PWRDN: begin
        if (freeze) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase

    // Counter restarts from zero on every state entry and saturates so a
    // long wait for the clock low phase cannot wrap it.
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q == CNT_SAT) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 1'b1;

    cam_pwdn_d  = (state_d == S_OFF);
    cam_rst_n_d = (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);
    busy_d      = (state_d == S_PWRUP) || (state_d == S_CLKON) || (state_d == S_PWRDN);
  end

  // Half-period divider and glitch-free reprogramming of its ratio.
  always_comb begin
    hcnt_d     = hcnt_q;
    cam_clk_d  = cam_clk_q;
    div_cur_d  = div_cur_q;
    pend_val_d = pend_val_q;
    pending_d  = pending_q;

    if (!div_run) begin
      // Parked low with the counter cleared, so CLKON entry starts a full
      // low phase of div_cur+1 cycles.
      hcnt_d    = '0;
      cam_clk_d = 1'b0;
    end else if (!freeze) begin
      if (half_done) begin
        hcnt_d    = '0;
        cam_clk_d = !cam_clk_q;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end

    // A new ratio takes effect at a rising toggle (it then shapes the high
    // phase that starts there) or at once while the divider is parked.
    apply = pending_q && (div_stopped || (tick && !cam_clk_q));
    if (apply) div_cur_d = pend_val_q;

    // A load in the application cycle stays pending for the next one.
    if (div_load) begin
      pend_val_d = div_half;
      pending_d  = 1'b1;
    end else if (apply) begin
      pending_d  = 1'b0;
    end

    div_ack_d = apply;
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      cam_clk_q   <= 1'b0;
      div_cur_q   <= DIV_RST;
      pend_val_q  <= DIV_RST;
      pending_q   <= 1'b0;
      div_ack_q   <= 1'b0;
      cam_pwdn_q  <= 1'b1;
      cam_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      cam_clk_q   <= cam_clk_d;
      div_cur_q   <= div_cur_d;
      pend_val_q  <= pend_val_d;
      pending_q   <= pending_d;
      div_ack_q   <= div_ack_d;
      cam_pwdn_q  <= cam_pwdn_d;
      cam_rst_n_q <= cam_rst_n_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign div_ack   = div_ack_q;
  assign cam_clk   = cam_clk_q;
  assign cam_pwdn  = cam_pwdn_q;
  assign cam_rst_n = cam_rst_n_q;
  assign ready     = ready_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_clk_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cam_clk_seq
//  Brief    : Directed self-checking bench for cam_clk_seq with
//             PWR=4, SETTLE=8, HOLD=4, DIV_INIT=4. Cycle 0 is the first
//             cycle after reset release; an input held during cycle N is
//             sampled at the edge that ends cycle N.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cam_clk_seq;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [DIV_W-1:0] div_half;
  logic             div_load;
  logic             div_ack;
  logic             cam_clk;
  logic             cam_pwdn;
  logic             cam_rst_n;
  logic             ready;
  logic             busy;

  int cyc;
  int n_cmp;
  int n_err;
  bit prev_clk;
  int rises[$];
  int falls[$];
  int acks[$];

  cam_clk_seq #(
    .DIV_W        (DIV_W),
    .DIV_INIT     (4),
    .PWR_CYCLES   (4),
    .SETTLE_CYCLES(8),
    .HOLD_CYCLES  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .div_half (div_half),
    .div_load (div_load),
    .div_ack  (div_ack),
    .cam_clk  (cam_clk),
    .cam_pwdn (cam_pwdn),
    .cam_rst_n(cam_rst_n),
    .ready    (ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // One clock: sample 1 time unit after the edge and log XCLK edges / acks.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cam_clk === 1'b1 && !prev_clk) rises.push_back(cyc);
    if (cam_clk === 1'b0 &&  prev_clk) falls.push_back(cyc);
    if (div_ack === 1'b1) acks.push_back(cyc);
    prev_clk = (cam_clk === 1'b1);
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic rebase();
    cyc = 0;
    rises.delete();
    falls.delete();
    acks.delete();
    prev_clk = (cam_clk === 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; div_load = 1'b0; div_half = '0;
    step();
    step();
    rst = 1'b0;
    rebase();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_val({tag, "_clk"},   cam_clk,   0);
    chk_val({tag, "_pwdn"},  cam_pwdn,  1);
    chk_val({tag, "_rstn"},  cam_rst_n, 0);
    chk_val({tag, "_ready"}, ready,     0);
    chk_val({tag, "_busy"},  busy,      0);
    chk_val({tag, "_ack"},   div_ack,   0);
  endtask

  // start in cycle 10: PWRUP at 11, CLKON at 15, first rise at 20, RUN at 23.
  task automatic power_up();
    run_to(10);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_val("up_pwdn11", cam_pwdn, 0);
    chk_val("up_busy11", busy, 1);
    chk_val("up_clk11",  cam_clk, 0);
    run_to(22);
    chk_val("up_ready22", ready, 0);
    chk_val("up_rstn22",  cam_rst_n, 0);
    step();
    chk_val("up_ready23", ready, 1);
    chk_val("up_rstn23",  cam_rst_n, 1);
    chk_val("up_busy23",  busy, 0);
    chk_val("up_rise_n",  rises.size(), 1);
    chk_val("up_rise0",   q_at(rises, 0), 20);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;

    // Scenario 1: reset values, power-up timing, steady 10-cycle period.
    do_reset();
    chk_reset_vals("rst");
    power_up();
    run_to(25);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_val("s1_start_ign", ready, 1);
    run_to(41);
    chk_val("s1_rise1", q_at(rises, 1), 30);
    chk_val("s1_rise2", q_at(rises, 2), 40);
    chk_val("s1_fall0", q_at(falls, 0), 25);
    chk_val("s1_fall1", q_at(falls, 1), 35);

    // Scenario 2: stop during a high phase (cycle 41).
    chk_val("s2_pre_clk", cam_clk, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_val("s2_rstn42",  cam_rst_n, 0);
    chk_val("s2_ready42", ready, 0);
    chk_val("s2_busy42",  busy, 1);
    run_to(46);
    chk_val("s2_pwdn46", cam_pwdn, 0);
    chk_val("s2_busy46", busy, 1);
    step();
    chk_val("s2_pwdn47", cam_pwdn, 1);
    chk_val("s2_busy47", busy, 0);
    chk_val("s2_fall2",  q_at(falls, 2), 45);
    run_to(70);
    chk_val("s2_rise_n", rises.size(), 3);
    chk_val("s2_clk70",  cam_clk, 0);

    // Scenario 3: reprogram to div_half=1 while running.
    do_reset();
    power_up();
    run_to(31);
    div_half = 8'd1; div_load = 1'b1;
    step();
    div_load = 1'b0;
    run_to(50);
    chk_val("s3_ack_n", acks.size(), 1);
    chk_val("s3_ack0",  q_at(acks, 0), 40);
    chk_val("s3_rise2", q_at(rises, 2), 40);
    chk_val("s3_fall2", q_at(falls, 2), 42);
    chk_val("s3_rise3", q_at(rises, 3), 44);
    chk_val("s3_rise4", q_at(rises, 4), 48);

    // Scenario 4: double load (2 then 7), then a load coinciding with an
    // application cycle (0 pending, 1 loaded in cycle 71).
    do_reset();
    power_up();
    run_to(31);
    div_half = 8'd2; div_load = 1'b1;
    step();
    div_load = 1'b0;
    run_to(33);
    div_half = 8'd7; div_load = 1'b1;
    step();
    div_load = 1'b0;
    run_to(60);
    div_half = 8'd0; div_load = 1'b1;
    step();
    div_load = 1'b0;
    run_to(71);
    div_half = 8'd1; div_load = 1'b1;
    step();
    div_load = 1'b0;
    run_to(80);
    chk_val("s4_ack_n", acks.size(), 3);
    chk_val("s4_ack0",  q_at(acks, 0), 40);
    chk_val("s4_fall2", q_at(falls, 2), 48);
    chk_val("s4_rise3", q_at(rises, 3), 56);
    chk_val("s4_ack1",  q_at(acks, 1), 72);
    chk_val("s4_rise4", q_at(rises, 4), 72);
    chk_val("s4_fall4", q_at(falls, 4), 73);
    chk_val("s4_ack2",  q_at(acks, 2), 74);
    chk_val("s4_rise5", q_at(rises, 5), 74);
    chk_val("s4_rise6", q_at(rises, 6), 78);

    // Scenario 5: load while parked, start+stop together, stop in PWRUP.
    do_reset();
    run_to(2);
    div_half = 8'd1; div_load = 1'b1;
    step();
    div_load = 1'b0;
    run_to(5);
    chk_val("s5_ack_n", acks.size(), 1);
    chk_val("s5_ack0",  q_at(acks, 0), 4);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk_val("s5_both_pwdn", cam_pwdn, 1);
    chk_val("s5_both_busy", busy, 0);
    run_to(10);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_val("s5_busy11", busy, 1);
    run_to(12);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_val("s5_pwdn13", cam_pwdn, 1);
    chk_val("s5_busy13", busy, 0);
    run_to(20);
    chk_val("s5_rise_n", rises.size(), 0);

    // Scenario 6: div_cur=1 now, so CLKON at 25 gives a rise at 27;
    // reset there, then the scenario-1 timing must reappear.
    start = 1'b1;
    step();
    start = 1'b0;
    run_to(27);
    chk_val("s6_pre_clk",  cam_clk, 1);
    chk_val("s6_pre_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_vals("s6rst");
    rebase();
    power_up();
    run_to(41);
    chk_val("s6_rise1", q_at(rises, 1), 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cam_clk_seq.md
# cam_clk_seq

Camera clock and power sequencer. It generates the camera master clock (XCLK) from the system clock through a runtime-programmable divider. It also drives camera power-down and reset in the sensor-mandated order, and applies divide-ratio changes without glitches. It sits between the register/control block (start, stop, divider writes) and the camera pads.

## Interface
- `DIV_W`, 8: width of the divider half-period field.
- `DIV_INIT`, 4: divider half-period value loaded at reset.
- `PWR_CYCLES`, 256: clk cycles from power-down release to XCLK start (≥1).
- `SETTLE_CYCLES`, 1024: clk cycles of running XCLK before camera reset release (≥1).
- `HOLD_CYCLES`, 64: clk cycles XCLK keeps running after reset assertion on power-down (≥1).
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that requests power-up.
- `stop` in 1: one-cycle pulse that requests power-down.
- `div_half` in DIV_W: new half-period minus 1. XCLK period = 2·(div_half+1) clk cycles; 0 is legal and gives clk/2.
- `div_load` in 1: one-cycle pulse that captures `div_half` into the pending register.
- `div_ack` out 1: one-cycle pulse in the cycle the pending value becomes active.
- `cam_clk` out 1: divided camera clock (registered).
- `cam_pwdn` out 1: camera power-down, active-high.
- `cam_rst_n` out 1: camera reset, active-low.
- `ready` out 1: high only in RUN.
- `busy` out 1: high in PWRUP, CLKON and PWRDN.

## Operation
- **States:** OFF, PWRUP, CLKON, RUN, PWRDN.
- **OFF:** `cam_pwdn`=1, `cam_rst_n`=0, `cam_clk` held 0. On `start` → PWRUP.
- **PWRUP:** `cam_pwdn`=0, clock stopped. After PWR_CYCLES cycles → CLKON. On `stop` → OFF.
- **CLKON:** divider runs, `cam_rst_n`=0. After SETTLE_CYCLES cycles → RUN. On `stop` → PWRDN.
- **RUN:** `cam_rst_n`=1, `ready`=1. On `stop` → PWRDN. `start` is ignored.
- **PWRDN:** `cam_rst_n`=0 immediately and the divider keeps running.
  - Once HOLD_CYCLES cycles have elapsed and `cam_clk`=0, freeze the divider.
  - Go to OFF next cycle; `cam_pwdn`=1 on OFF entry.
  - The high phase is never truncated.
- **Request filtering:** `start` outside OFF is ignored. `stop` in OFF or PWRDN is ignored. `start` and `stop` in the same cycle: `stop` wins.
- **Divider:**
  - Half-period counter `hcnt` counts 0..`div_cur`.
  - At `hcnt`==`div_cur`, `cam_clk` toggles and `hcnt` returns to 0.
  - On CLKON entry, `hcnt`=0 and `cam_clk`=0, so the first rising edge comes `div_cur`+1 cycles after entry.
- **Divider reprogramming:**
  - `div_load` writes `div_half` to the pending register and sets a pending flag. A second load before application overwrites the value; only one `div_ack` is produced.
  - While the divider runs, pending is applied only at a low→high toggle, i.e. `hcnt`==`div_cur` with `cam_clk`=0. The new value governs the following high phase and onward.
  - While the divider is stopped (OFF, PWRUP), pending is applied the cycle after the load.
  - If `div_load` coincides with an application cycle, the old pending value is applied with `div_ack`. The new value remains pending.
- **Wait counters:** one shared counter, width $clog2(max(PWR,SETTLE,HOLD)+1), cleared on every state entry.

## Timing
- **Reset values:** state OFF, `cam_clk`=0, `cam_pwdn`=1, `cam_rst_n`=0, `ready`=0, `busy`=0, `div_ack`=0, pending cleared, `div_cur`=DIV_INIT. Reset mid-operation forces these values in the next cycle, regardless of clock phase.
- **Power-up sequence,** with `start` sampled at edge T:
  - T+1: PWRUP, `cam_pwdn`=0, `busy`=1.
  - T+1+PWR_CYCLES: CLKON.
  - T+1+PWR_CYCLES+`div_cur`+1: first `cam_clk` rise.
  - T+1+PWR_CYCLES+SETTLE_CYCLES: RUN, `cam_rst_n`=1, `ready`=1, `busy`=0.
- **Power-down from RUN,** with `stop` at edge S:
  - S+1: `cam_rst_n`=0, `ready`=0, `busy`=1.
  - Clock freezes at the first cycle ≥ S+1+HOLD_CYCLES with `cam_clk`=0.
  - OFF one cycle later.
- **Outputs:** all registered; no combinational input→output path.
- **`div_ack`:** asserted in the same cycle as the first `cam_clk` edge under the new `div_cur`.

## Test plan
Parameters for all scenarios: PWR=4, SETTLE=8, HOLD=4, DIV_INIT=4.
1. Reset, then `start` at cycle 10 → `cam_pwdn` falls at 11; first `cam_clk` rise at 20; `cam_rst_n`/`ready` rise at 23; steady XCLK period is 10 cycles.
2. In RUN, `stop` while `cam_clk`=1 → `cam_rst_n` falls next cycle; the high phase completes its full 5 cycles; the clock freezes low; `cam_pwdn`=1 the following cycle; no runt pulses.
3. In RUN, `div_load` with `div_half`=1 → `div_ack` coincides with the next low→high edge; every later half-period is 2 cycles; no phase shorter than min(old,new).
4. Two `div_load`s (values 2 then 7) before application → a single `div_ack`; the period becomes 16.
5. `start` and `stop` in the same cycle in OFF → stays OFF. `stop` during PWRUP → OFF next cycle with `cam_pwdn`=1 and no `cam_clk` edge.
6. `rst` asserted in CLKON with `cam_clk`=1 → next cycle all outputs at reset values, `div_cur`=4; a later `start` repeats the timing of scenario 1.
